// File: rtl/wts_channel_mixer_pkg.sv
// Shared constants and helpers for the wavetable channel mixer and its scaler.
package wts_channel_mixer_pkg;

  // Envelope full scale and the shift that maps a full-scale envelope back to unity gain
  localparam int WTS_ENV_MAX     = 128;
  localparam int WTS_ENV_SHIFT   = 7;
  localparam int WTS_SAMPLE_BITS = 8;
  localparam int WTS_VOL_BITS    = 4;

  // Channel count shared with the envelope and register blocks
  localparam int WTS_CHANNELS    = 5;

  // Width of the channel-select bus driven back to the upstream mux
  localparam int WTS_INDEX_BITS  = 3;

  // One scaled channel term: -128..127 times 0..15 fits in 12 signed bits
  localparam int WTS_TERM_BITS   = 12;

  typedef logic signed [WTS_SAMPLE_BITS-1:0] wts_sample_t;
  typedef logic signed [WTS_TERM_BITS-1:0]   wts_term_t;

  // Envelope levels above full scale are treated as full scale
  function automatic logic [WTS_SAMPLE_BITS-1:0] wts_env_clamp(
    input logic [WTS_SAMPLE_BITS-1:0] env
  );
    if (env > WTS_SAMPLE_BITS'(WTS_ENV_MAX)) begin
      return WTS_SAMPLE_BITS'(WTS_ENV_MAX);
    end
    return env;
  endfunction

endpackage

// File: rtl/wts_channel_scaler.sv
// Combinational per-channel gain: envelope scaling for the capture stage and
// volume scaling for the accumulate stage.
module wts_channel_scaler
  import wts_channel_mixer_pkg::*;
(
  input  logic signed [WTS_SAMPLE_BITS-1:0] sample,
  input  logic        [WTS_SAMPLE_BITS-1:0] envelope,
  output wts_sample_t                       scaled,
  input  wts_sample_t                       scaled_p1,
  input  logic        [WTS_VOL_BITS-1:0]    volume_p1,
  input  logic                              mute_p1,
  output wts_term_t                         term
);

  // Signed sample times a 9-bit non-negative envelope
  localparam int PROD_W = 2 * WTS_SAMPLE_BITS + 1;

  logic        [WTS_SAMPLE_BITS-1:0] env_clamped;
  logic signed [WTS_SAMPLE_BITS:0]   env_s;
  logic signed [PROD_W-1:0]          prod_full;
  logic signed [WTS_VOL_BITS:0]      vol_s;
  wts_term_t                         term_full;

  // Envelope clamp and multiply; the arithmetic shift floors toward minus infinity,
  // which keeps the result inside -128..127 for any clamped envelope.
  assign env_clamped = wts_env_clamp(envelope);
  assign env_s       = $signed({1'b0, env_clamped});
  assign prod_full   = PROD_W'(sample) * PROD_W'(env_s);
  assign scaled      = WTS_SAMPLE_BITS'(prod_full >>> WTS_ENV_SHIFT);

  // Volume multiply on the registered envelope-scaled value; muted channels add nothing
  assign vol_s     = $signed({1'b0, volume_p1});
  assign term_full = WTS_TERM_BITS'(scaled_p1) * WTS_TERM_BITS'(vol_s);
  assign term      = mute_p1 ? '0 : term_full;

endmodule

// File: rtl/wts_channel_mixer.sv
// Time-multiplexed channel mixer: walks CHANNELS slots per frame, scales each
// channel by envelope and volume, sums the frame and presents a saturated sample.
module wts_channel_mixer
  import wts_channel_mixer_pkg::*;
#(
  parameter int CHANNELS = WTS_CHANNELS,
  parameter int OUT_BITS = 12
) (
  input  logic                              clk,
  input  logic                              nreset,
  input  logic                              active,
  output logic        [WTS_INDEX_BITS-1:0]  ch_index,
  input  logic signed [WTS_SAMPLE_BITS-1:0] ch_sample,
  input  logic        [WTS_SAMPLE_BITS-1:0] ch_envelope,
  input  logic        [WTS_VOL_BITS-1:0]    ch_volume,
  input  logic        [CHANNELS-1:0]        ch_mute,
  output logic signed [OUT_BITS-1:0]        sound_out,
  output logic                              sample_valid
);

  // Accumulator headroom covers CHANNELS worst-case terms
  localparam int ACC_W   = WTS_TERM_BITS + $clog2(CHANNELS);
  localparam int SLOT_W  = $clog2(CHANNELS + 2);
  localparam int OUT_MAX = (1 <<< (OUT_BITS - 1)) - 1;
  localparam int OUT_MIN = -(1 <<< (OUT_BITS - 1));

  localparam logic [SLOT_W-1:0] CH_SLOT   = SLOT_W'(CHANNELS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS + 1);

  logic [SLOT_W-1:0]          ff_slot;
  logic [SLOT_W-1:0]          slot_next;
  logic                       capture;
  logic                       frame_close;
  logic                       mute_sel;

  wts_sample_t                scaled;
  wts_sample_t                scaled_p1;
  logic [WTS_VOL_BITS-1:0]    volume_p1;
  logic                       mute_p1;
  logic                       vld_p1;

  wts_term_t                  term;
  logic signed [ACC_W-1:0]    acc_p2;
  logic signed [ACC_W-1:0]    acc_sum;

  // Clamp the frame total into the output range
  function automatic logic signed [OUT_BITS-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    int vi;
    vi = int'(v);
    if (vi > OUT_MAX) begin
      vi = OUT_MAX;
    end else if (vi < OUT_MIN) begin
      vi = OUT_MIN;
    end
    return OUT_BITS'(vi);
  endfunction

  assign slot_next   = (ff_slot == LAST_SLOT) ? '0 : ff_slot + SLOT_W'(1);
  assign capture     = (ff_slot != '0) && (ff_slot <= CH_SLOT);
  assign frame_close = (ff_slot == LAST_SLOT);
  assign acc_sum     = acc_p2 + ACC_W'(term);

  // Mute bit of the channel captured in this slot (slot s carries channel s-1)
  always_comb begin
    mute_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ff_slot == SLOT_W'(i + 1)) begin
        mute_sel = ch_mute[i];
      end
    end
  end

  wts_channel_scaler u_scaler (
    .sample    (ch_sample),
    .envelope  (ch_envelope),
    .scaled    (scaled),
    .scaled_p1 (scaled_p1),
    .volume_p1 (volume_p1),
    .mute_p1   (mute_p1),
    .term      (term)
  );

  // Slot counter and registered channel request, both advancing once per active pulse
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ff_slot  <= '0;
      ch_index <= '0;
    end else if (active) begin
      ff_slot  <= slot_next;
      ch_index <= (slot_next < CH_SLOT) ? WTS_INDEX_BITS'(slot_next) : '0;
    end
  end

  // ---- stage 1: capture envelope-scaled sample, volume and mute of channel s-1 ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_p1    <= 1'b0;
      scaled_p1 <= '0;
      volume_p1 <= '0;
      mute_p1   <= 1'b0;
    end else if (active) begin
      vld_p1 <= capture;
      if (capture) begin
        scaled_p1 <= scaled;
        volume_p1 <= ch_volume;
        mute_p1   <= mute_sel;
      end
    end
  end

  // ---- stage 2: accumulate volume-scaled terms; close the frame into sound_out ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_p2    <= '0;
      sound_out <= '0;
    end else if (active) begin
      if (frame_close) begin
        sound_out <= sat_out(acc_sum);
        acc_p2    <= '0;
      end else if (vld_p1) begin
        acc_p2 <= acc_sum;
      end
    end
  end

  // Strobe for exactly one clk after each frame close, independent of the active pulse
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= active && frame_close;
    end
  end

endmodule
